// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops that can act as independent T-FFs or as a
// synchronous up/down counter built from a T-chain. Wrap or saturate at terminal count.
module t_ff_bank #(
  parameter int                 WIDTH       = 4,
  parameter bit                 SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;

  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;
  logic [WIDTH-1:0] tog;
  logic             up_carry;
  logic             dn_carry;
  logic             count_event;

  // T-chain enables: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_carry = 1'b1;
    dn_carry = 1'b1;
    up_tog   = '0;
    dn_tog   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_tog[i] = up_carry;
      dn_tog[i] = dn_carry;
      up_carry  = up_carry & q[i];
      dn_carry  = dn_carry & ~q[i];
    end
  end

  assign tc = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DOWN) && ~(|q));
  assign count_event = en && tc;

  always_comb begin
    tog = '0;
    if (en) begin
      case (mode)
        MODE_TOGGLE: tog = t;
        MODE_UP:     tog = up_tog;
        MODE_DOWN:   tog = dn_tog;
        default:     tog = '0;
      endcase
      // Saturating counters freeze at the terminal value instead of wrapping.
      if (SATURATE && count_event) tog = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RESET_VALUE;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= d;
      ovf <= 1'b0;
    end else begin
      q   <= q ^ tog;
      ovf <= count_event;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_t_ff_bank.sv
// Drives three t_ff_bank instances (wrap, saturate, RESET_VALUE=1010) with shared
// stimulus; an arithmetic reference model fills a queue that a monitor drains.
module tb_t_ff_bank;

  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b11;
  logic [W-1:0] t = '0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;

  logic [W-1:0] q_v    [N];
  logic [W-1:0] qbar_v [N];
  logic         tc_v   [N];
  logic         ovf_v  [N];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    t_ff_bank #(
      .WIDTH(W),
      .SATURATE(k == 1),
      .RESET_VALUE((k == 2) ? 4'b1010 : 4'b0000)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t),
      .load(load), .d(d),
      .q(q_v[k]), .qbar(qbar_v[k]), .tc(tc_v[k]), .ovf(ovf_v[k])
    );
  end

  // Per instance: {ovf, q} expected after the next rising edge.
  logic [5*N-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  bit           cfg_sat [N] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] cfg_rv  [N] = '{4'b0000, 4'b0000, 4'b1010};
  logic [W-1:0] mq      [N];

  task automatic chk(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s inst%0d at %0t: got %b expected %b", name, k, $time, act, exp);
    else
      passes++;
  endtask

  function automatic logic [4:0] model_step(input logic [W-1:0] cur, input bit sat,
      input logic [W-1:0] rv, input logic r, ld, e, input logic [1:0] m,
      input logic [W-1:0] tt, dd);
    int v;
    v = int'(cur);
    if (r)                   return {1'b0, rv};
    if (ld)                  return {1'b0, dd};
    if (!e || m == 2'b11)    return {1'b0, cur};
    if (m == 2'b00)          return {1'b0, cur ^ tt};
    if (m == 2'b01) begin
      if (v == 15) return sat ? 5'b1_1111 : 5'b1_0000;
      v = v + 1;
      return {1'b0, v[3:0]};
    end
    if (v == 0) return sat ? 5'b1_0000 : 5'b1_1111;
    v = v - 1;
    return {1'b0, v[3:0]};
  endfunction

  function automatic logic model_tc(input logic [W-1:0] cur, input logic [1:0] m);
    return (m == 2'b01 && int'(cur) == 15) || (m == 2'b10 && int'(cur) == 0);
  endfunction

  bit mvalid = 1'b0;

  task automatic cyc(input logic r, ld, e, input logic [1:0] m, input logic [W-1:0] tt, dd);
    logic [5*N-1:0] e_all;
    logic [4:0] s;
    @(negedge clk);
    rst = r; load = ld; en = e; mode = m; t = tt; d = dd;
    #1;
    if (mvalid)
      for (int k = 0; k < N; k++)
        chk("tc", k, {3'b000, tc_v[k]}, {3'b000, model_tc(mq[k], m)});
    for (int k = 0; k < N; k++) begin
      s = model_step(mq[k], cfg_sat[k], cfg_rv[k], r, ld, e, m, tt, dd);
      mq[k] = s[3:0];
      e_all[k*5 +: 5] = s;
    end
    if (r) mvalid = 1'b1;
    if (mvalid) exp_q.push_back(e_all);
  endtask

  // Monitor: every edge that has an expectation outstanding is checked.
  initial begin
    logic [5*N-1:0] e_all;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e_all = exp_q.pop_front();
        for (int k = 0; k < N; k++) begin
          chk("q", k, q_v[k], e_all[k*5 +: 4]);
          chk("qbar", k, qbar_v[k], ~e_all[k*5 +: 4]);
          chk("ovf", k, {3'b000, ovf_v[k]}, {3'b000, e_all[k*5+4]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then toggle bank with t=0101.
    cyc(1, 0, 0, 2'b00, 4'h0, 4'h0);
    cyc(1, 0, 0, 2'b00, 4'h0, 4'h0);
    repeat (3) cyc(0, 0, 1, 2'b00, 4'b0101, 4'h0);
    // Full up-count through the terminal value.
    cyc(1, 0, 0, 2'b01, 4'h0, 4'h0);
    repeat (17) cyc(0, 0, 1, 2'b01, 4'h0, 4'h0);
    // Down-count from 2 into the bottom.
    cyc(0, 1, 0, 2'b10, 4'h0, 4'b0010);
    repeat (4) cyc(0, 0, 1, 2'b10, 4'hf, 4'h0);
    // Load colliding with a count event.
    cyc(0, 1, 0, 2'b01, 4'h0, 4'b1111);
    cyc(0, 1, 1, 2'b01, 4'h0, 4'b1000);
    cyc(0, 0, 1, 2'b01, 4'h0, 4'h0);
    // Reset mid-count, enable low, hold mode.
    cyc(1, 0, 0, 2'b01, 4'h0, 4'h0);
    repeat (6) cyc(0, 0, 1, 2'b01, 4'h0, 4'h0);
    cyc(1, 1, 1, 2'b01, 4'h0, 4'h5);
    repeat (2) cyc(0, 0, 1, 2'b01, 4'h0, 4'h0);
    repeat (2) cyc(0, 0, 0, 2'b01, 4'hf, 4'h0);
    repeat (2) cyc(0, 0, 1, 2'b11, 4'hf, 4'h0);
    // Direction change mid-stream.
    cyc(1, 0, 0, 2'b01, 4'h0, 4'h0);
    cyc(0, 0, 1, 2'b01, 4'h0, 4'h0);
    cyc(0, 0, 1, 2'b10, 4'h0, 4'h0);
    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/t_ff_bank.md
T_FF_BANK -- requirements
Module: t_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of flip-flop channels (WIDTH >= 2).
REQ-002 Parameter SATURATE, default 0; 0 = counter wraps at terminal count, 1 = counter holds at terminal count.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  update enable; 0 = all channels hold.
REQ-007 mode  input  2  00 toggle bank, 01 up count, 10 down count, 11 hold.
REQ-008 t  input  WIDTH  per-channel toggle request, used only in mode 00.
REQ-009 load  input  1  parallel load strobe.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 q  output  WIDTH  registered flip-flop state.
REQ-012 qbar  output  WIDTH  bitwise complement of q.
REQ-013 tc  output  1  terminal-count flag, combinational.
REQ-014 ovf  output  1  registered one-cycle wrap/saturation pulse.

Function
REQ-015 Update priority on each rising clk edge SHALL be rst > load > (en with mode) > hold.
REQ-016 load=1 (rst=0) SHALL set q <= d and ovf <= 0 regardless of en and mode.
REQ-017 en=0 with load=0 SHALL hold q and drive ovf <= 0.
REQ-018 Mode 00 with en=1: q[i] SHALL toggle if t[i]=1, hold if t[i]=0, independently per channel, one-cycle latency.
REQ-019 Mode 01 with en=1: q SHALL become q+1 modulo 2^WIDTH (synchronous T-chain: bit i toggles when bits 0..i-1 all 1).
REQ-020 Mode 10 with en=1: q SHALL become q-1 modulo 2^WIDTH (bit i toggles when bits 0..i-1 all 0).
REQ-021 Mode 11 SHALL hold q irrespective of en and t; ovf <= 0.
REQ-022 t SHALL be ignored in modes 01, 10, 11.
REQ-023 qbar SHALL equal ~q at all times, including during and immediately after reset.
REQ-024 tc SHALL be 1 when (mode=01 and q all ones) or (mode=10 and q all zeros), else 0; it reacts combinationally to mode changes.
REQ-025 Count event = en=1, load=0, rst=0, tc=1 at the clock edge; ovf SHALL be 1 for exactly the following cycle, else 0.
REQ-026 SATURATE=0: on count event q SHALL wrap (all ones -> 0 up, 0 -> all ones down).
REQ-027 SATURATE=1: on count event q SHALL hold its terminal value; ovf SHALL still pulse; ovf repeats every cycle while the event persists.
REQ-028 A mode change SHALL take effect at the next rising edge; no state is lost or skipped on change.
REQ-029 Simultaneous load and count event: load wins, ovf <= 0.

Reset
REQ-030 rst=1 at a rising edge SHALL set q <= RESET_VALUE, ovf <= 0, overriding load, en, mode.
REQ-031 Reset asserted mid-count SHALL take effect at the next edge; counting resumes from RESET_VALUE on the first edge after rst deasserts (if en=1).
REQ-032 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply rst for >= 2 cycles at start.

Verification (WIDTH=4, RESET_VALUE=0 unless stated)
REQ-033 rst=1 two cycles, then mode=00, en=1, t=4'b0101 for 3 edges -> q: 0101, 0000, 0101; qbar = ~q each cycle; ovf=0.
REQ-034 SATURATE=0, mode=01, en=1 from q=0 for 17 edges -> q counts 1..15, 0, 1; tc=1 while q=15; ovf=1 only in the cycle after 15->0.
REQ-035 SATURATE=1, load d=4'b0010, then mode=10, en=1 for 4 edges -> q: 0001, 0000, 0000, 0000; ovf=1 in last two cycles.
REQ-036 mode=01, q=15, en=1, load=1 d=4'b1000 same edge -> q=1000, ovf=0; next edge with load=0 -> q=1001.
REQ-037 mode=01 counting at q=6, rst=1 one edge -> q=0, ovf=0; en toggled 0 for 2 edges -> q holds; mode=11 with en=1 -> q holds.
REQ-038 RESET_VALUE=4'b1010, rst pulse -> q=1010, qbar=0101; mode switched 01->10 at q=1011 -> next q=1010.
